// File: rtl/lanectrl_pkg.sv
// Shared definitions for the lane-controller pause path: sequencer states, window counter
// width and the default timing constants also used by the pause-sync wrapper.
package lanectrl_pkg;

    localparam int CNT_W = 5;

    localparam int DEF_SETUP_CYCLES = 4;
    localparam int DEF_SYNC_LATENCY = 2;
    localparam int DEF_HOLD_CYCLES  = 4;
    localparam int DEF_GAP_CYCLES   = 8;
    localparam int DEF_CODE_W       = 8;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        SETUP,
        LOAD,
        HOLD,
        RELEASE,
        GAP
    } seq_state_t;

    // Pause is requested in every state that brackets the load strobe.
    function automatic logic pause_state(input seq_state_t st);
        return (st == SETUP) || (st == LOAD) || (st == HOLD);
    endfunction

endpackage

// File: rtl/lanectrl_win_counter.sv
// Loadable down-counter that times the sequencer windows; terminal marks the last counted cycle.
module lanectrl_win_counter
    import lanectrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(1));

endmodule

// File: rtl/lanectrl_pause_sequencer.sv
// Delay-code update sequencer: wraps each code load in a guarded HS IO clock pause window
// and acknowledges the requester once pause has been released.
module lanectrl_pause_sequencer
    import lanectrl_pkg::*;
#(
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int SYNC_LATENCY = DEF_SYNC_LATENCY,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int CODE_W       = DEF_CODE_W,
    parameter int SKIP_SAME    = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              UPD_REQ,
    input  logic [CODE_W-1:0] UPD_CODE,
    output logic              UPD_ACK,
    output logic              HS_IO_CLK_PAUSE,
    output logic              CODE_LOAD,
    output logic [CODE_W-1:0] CODE_OUT,
    output logic              BUSY
);

    // Setup window covers the downstream synchroniser so the load lands inside the paused clock.
    localparam logic [CNT_W-1:0] SETUP_LEN = CNT_W'(SETUP_CYCLES + SYNC_LATENCY);
    localparam logic [CNT_W-1:0] HOLD_LEN  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LEN   = CNT_W'(GAP_CYCLES);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [CODE_W-1:0] code_cap;
    logic              code_valid;
    logic              capture;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_value;
    logic              cnt_dec;
    logic              cnt_term;
    logic              same_code;

    lanectrl_win_counter u_win_counter (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .terminal   (cnt_term)
    );

    assign same_code = (SKIP_SAME != 0) && code_valid && (UPD_CODE == CODE_OUT);

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        cnt_load   = 1'b0;
        cnt_value  = '0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (UPD_REQ) begin
                    capture = 1'b1;
                    if (same_code) begin
                        state_next = SKIP;
                    end else begin
                        state_next = SETUP;
                        cnt_load   = 1'b1;
                        cnt_value  = SETUP_LEN;
                    end
                end
            end
            SKIP: begin
                state_next = IDLE;
            end
            SETUP: begin
                if (cnt_term) begin
                    state_next = LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            LOAD: begin
                state_next = HOLD;
                cnt_load   = 1'b1;
                cnt_value  = HOLD_LEN;
            end
            HOLD: begin
                if (cnt_term) begin
                    state_next = RELEASE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RELEASE: begin
                if (GAP_CYCLES == 0) begin
                    state_next = IDLE;
                end else begin
                    state_next = GAP;
                    cnt_load   = 1'b1;
                    cnt_value  = GAP_LEN;
                end
            end
            GAP: begin
                if (cnt_term) begin
                    state_next = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state           <= IDLE;
            HS_IO_CLK_PAUSE <= 1'b0;
            CODE_LOAD       <= 1'b0;
            UPD_ACK         <= 1'b0;
            BUSY            <= 1'b0;
            CODE_OUT        <= '0;
            code_valid      <= 1'b0;
        end else begin
            state           <= state_next;
            HS_IO_CLK_PAUSE <= pause_state(state_next);
            CODE_LOAD       <= (state_next == LOAD);
            UPD_ACK         <= (state_next == SKIP) || (state_next == RELEASE);
            BUSY            <= (state_next != IDLE);
            if (state_next == LOAD) begin
                CODE_OUT   <= code_cap;
                code_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (capture) begin
            code_cap <= UPD_CODE;
        end
    end

endmodule

// File: tb/tb_lanectrl_pause_sequencer.sv
// Directed bench for the pause sequencer: default-timing instance plus a minimum-timing instance.
module tb_lanectrl_pause_sequencer;

    logic       clk;
    logic       rst_n;
    logic       req,  req5;
    logic [7:0] code, code5;
    logic       ack,  ack5;
    logic       pause, pause5;
    logic       load,  load5;
    logic [7:0] code_out, code_out5;
    logic       busy, busy5;

    int checks;
    int errors;
    int loads_m, loads_5;
    bit pseen_m, pseen_5;

    typedef struct {
        logic       req;
        logic [7:0] code;
        logic       pause;
        logic       load;
        logic       ack;
        logic       busy;
        logic [7:0] code_out;
    } vec_t;

    vec_t tbl1[22];
    vec_t tbl5[10];

    lanectrl_pause_sequencer dut (
        .CLK             (clk),
        .RESET_N         (rst_n),
        .UPD_REQ         (req),
        .UPD_CODE        (code),
        .UPD_ACK         (ack),
        .HS_IO_CLK_PAUSE (pause),
        .CODE_LOAD       (load),
        .CODE_OUT        (code_out),
        .BUSY            (busy)
    );

    lanectrl_pause_sequencer #(
        .SETUP_CYCLES (1),
        .SYNC_LATENCY (0),
        .HOLD_CYCLES  (1),
        .GAP_CYCLES   (0)
    ) dut5 (
        .CLK             (clk),
        .RESET_N         (rst_n),
        .UPD_REQ         (req5),
        .UPD_CODE        (code5),
        .UPD_ACK         (ack5),
        .HS_IO_CLK_PAUSE (pause5),
        .CODE_LOAD       (load5),
        .CODE_OUT        (code_out5),
        .BUSY            (busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; also enforce the load/ack invariants.
    task automatic step();
        @(posedge clk);
        #1;
        if (load) begin
            chk1("prop load_implies_pause", pause, 1'b1);
            loads_m++;
        end
        if (pause) pseen_m = 1'b1;
        if (ack) begin
            chk1("prop ack_after_one_load_or_skip",
                 (loads_m == 1) || (loads_m == 0 && !pseen_m), 1'b1);
            loads_m = 0;
            pseen_m = 1'b0;
        end
        if (load5) begin
            chk1("prop5 load_implies_pause", pause5, 1'b1);
            loads_5++;
        end
        if (pause5) pseen_5 = 1'b1;
        if (ack5) begin
            chk1("prop5 ack_after_one_load_or_skip",
                 (loads_5 == 1) || (loads_5 == 0 && !pseen_5), 1'b1);
            loads_5 = 0;
            pseen_5 = 1'b0;
        end
    endtask

    initial begin
        int c;
        int low_run;
        checks  = 0;
        errors  = 0;
        loads_m = 0;
        loads_5 = 0;
        pseen_m = 1'b0;
        pseen_5 = 1'b0;
        rst_n   = 1'b0;
        req     = 1'b0;
        code    = 8'h00;
        req5    = 1'b0;
        code5   = 8'h00;

        // Test 1 table: accept 0x3A at the first edge, code bus changes while busy are ignored.
        for (int k = 0; k < 22; k++) begin
            c = k + 1;
            tbl1[k].req      = (k <= 11);
            tbl1[k].code     = (k == 0) ? 8'h3A : 8'hFF;
            tbl1[k].pause    = (c >= 1 && c <= 11);
            tbl1[k].load     = (c == 7);
            tbl1[k].ack      = (c == 12);
            tbl1[k].busy     = (c <= 20);
            tbl1[k].code_out = (c >= 7) ? 8'h3A : 8'h00;
        end

        // Test 5 table: minimum timing, request held across the first ack with a new code.
        for (int k = 0; k < 10; k++) begin
            c = k + 1;
            tbl5[k].req      = (k <= 8);
            tbl5[k].code     = (k <= 1) ? 8'h21 : 8'h22;
            tbl5[k].pause    = (c == 1 || c == 2 || c == 3 || c == 6 || c == 7 || c == 8);
            tbl5[k].load     = (c == 2 || c == 7);
            tbl5[k].ack      = (c == 4 || c == 9);
            tbl5[k].busy     = (c != 5 && c != 10);
            tbl5[k].code_out = (c < 2) ? 8'h00 : ((c < 7) ? 8'h21 : 8'h22);
        end

        step();
        step();
        chk1("reset pause", pause, 1'b0);
        chk1("reset load", load, 1'b0);
        chk1("reset ack", ack, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk8("reset code_out", code_out, 8'h00);
        chk1("reset pause5", pause5, 1'b0);
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 22; k++) begin
            req  = tbl1[k].req;
            code = tbl1[k].code;
            step();
            chk1($sformatf("t1 pause c%0d", k + 1), pause, tbl1[k].pause);
            chk1($sformatf("t1 load c%0d", k + 1), load, tbl1[k].load);
            chk1($sformatf("t1 ack c%0d", k + 1), ack, tbl1[k].ack);
            chk1($sformatf("t1 busy c%0d", k + 1), busy, tbl1[k].busy);
            chk8($sformatf("t1 code_out c%0d", k + 1), code_out, tbl1[k].code_out);
        end

        // Test 2: same code again is acknowledged without a pause window.
        req  = 1'b1;
        code = 8'h3A;
        step();
        chk1("t2 skip ack", ack, 1'b1);
        chk1("t2 skip pause", pause, 1'b0);
        chk1("t2 skip load", load, 1'b0);
        chk1("t2 skip busy", busy, 1'b1);
        req = 1'b0;
        step();
        chk1("t2 after ack", ack, 1'b0);
        chk1("t2 after busy", busy, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("t2 no pause", pause, 1'b0);
        end

        // Test 3: request held across ack; second window waits out the gap.
        req     = 1'b1;
        code    = 8'h55;
        low_run = 0;
        for (int k = 1; k <= 42; k++) begin
            step();
            if (k >= 12 && k <= 21 && !pause) low_run++;
            if (k == 7) chk8("t3 first code_out", code_out, 8'h55);
            if (k == 12) begin
                chk1("t3 first ack", ack, 1'b1);
                code = 8'h10;
            end
            if (k == 21) chk1("t3 pause low before second", pause, 1'b0);
            if (k == 22) chk1("t3 second pause rise", pause, 1'b1);
            if (k == 28) begin
                chk1("t3 second load", load, 1'b1);
                chk8("t3 second code_out", code_out, 8'h10);
            end
            if (k == 33) begin
                chk1("t3 second ack", ack, 1'b1);
                req = 1'b0;
            end
            if (k == 42) chk1("t3 idle after gap", busy, 1'b0);
        end
        chki("t3 pause low run", low_run, 10);

        // Test 4: reset during HOLD abandons the window; a later 0x00 request gets a full window.
        req  = 1'b1;
        code = 8'h77;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 1) req = 1'b0;
        end
        chk1("t4 pause in hold", pause, 1'b1);
        chk8("t4 code_out in hold", code_out, 8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("t4 async pause", pause, 1'b0);
        chk1("t4 async busy", busy, 1'b0);
        chk8("t4 async code_out", code_out, 8'h00);
        loads_m = 0;
        pseen_m = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk1("t4 no ack in reset", ack, 1'b0);
        end
        rst_n = 1'b1;
        step();
        chk1("t4 no ack after reset", ack, 1'b0);
        req  = 1'b1;
        code = 8'h00;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 1) begin
                chk1("t4 new window pause", pause, 1'b1);
                req = 1'b0;
            end
            if (k == 7) begin
                chk1("t4 new window load", load, 1'b1);
                chk8("t4 new window code_out", code_out, 8'h00);
            end
            if (k == 12) chk1("t4 new window ack", ack, 1'b1);
            if (k == 13) chk1("t4 single ack", ack, 1'b0);
        end
        for (int k = 0; k < 10; k++) step();

        // Test 5: minimum-timing instance.
        for (int k = 0; k < 10; k++) begin
            req5  = tbl5[k].req;
            code5 = tbl5[k].code;
            step();
            chk1($sformatf("t5 pause c%0d", k + 1), pause5, tbl5[k].pause);
            chk1($sformatf("t5 load c%0d", k + 1), load5, tbl5[k].load);
            chk1($sformatf("t5 ack c%0d", k + 1), ack5, tbl5[k].ack);
            chk1($sformatf("t5 busy c%0d", k + 1), busy5, tbl5[k].busy);
            chk8($sformatf("t5 code_out c%0d", k + 1), code_out5, tbl5[k].code_out);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
